io_controller: RTL and testbench
================================

// Module: io_controller
// PURPOSE
//  Sequences the basic computer's character I/O: buffers input bytes from an external device
//  into a small FIFO feeding INPR/FGI, and drives OUTR bytes to an external device over a
//  valid/ready handshake while maintaining FGO. Sits between the datapath/controller and the
//  I/O devices; raises INT_req for the controller's interrupt cycle.
// PARAMETERS
//  DEPTH   4   input FIFO entries; power of two, >= 2
//  DATA_W  8   character width (INPR, OUTR, device data)
// PORTS
//  clock       in   1       system clock, all state updates on rising edge
//  reset       in   1       synchronous, active-high reset
//  IN_valid    in   1       input device offers IN_data
//  IN_data     in   DATA_W  input device byte
//  IN_ready    out  1       FIFO can accept (= not full)
//  INP_take    in   1       controller executes INP this cycle: pop head into AC
//  INPR        out  DATA_W  FIFO head byte (0 when empty)
//  FGI         out  1       input flag: FIFO not empty
//  OUTR_load   in   1       controller executes OUT this cycle
//  AC_low      in   DATA_W  AC[DATA_W-1:0], byte to send
//  OUT_valid   out  1       byte held on OUT_data for output device
//  OUT_data    out  DATA_W  OUTR contents
//  OUT_ready   in   1       output device accepts OUT_data
//  FGO         out  1       output flag: OUTR free for a new byte
//  IEN_out     in   1       interrupt enable flip-flop
//  INT_req     out  1       IEN_out & (FGI | FGO), combinational
//  IN_ovf      out  1       sticky: INP_take seen while FIFO empty
//  OUT_drop    out  1       sticky: OUTR_load seen while FGO=0
// BEHAVIOUR
//  Reset (synchronous, overrides all inputs in that cycle): FIFO count/pointers 0, FGI=0,
//   INPR=0, IN_ready=1, OUT_valid=0, OUT_data=0, FGO=1, IN_ovf=0, OUT_drop=0.
//  Input FIFO: push when IN_valid & IN_ready; pop when INP_take & FGI.
//   - Byte pushed at edge N into empty FIFO: FGI=1 and INPR=byte from cycle N+1.
//   - INPR/FGI reflect registered FIFO state only (no input->output comb path).
//   - Push+pop same cycle with 0<count<DEPTH: count unchanged, head advances, new byte at tail.
//   - Full (count=DEPTH): IN_ready=0, no push; a pop the same cycle does not enable a push.
//   - INP_take when empty: no state change except IN_ovf<=1.
//   - Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
//  Output FSM, two states:
//   OUT_IDLE: FGO=1, OUT_valid=0. OUTR_load -> OUT_data<=AC_low, go OUT_SEND.
//   OUT_SEND: FGO=0, OUT_valid=1, OUT_data stable. OUT_ready -> OUT_IDLE.
//    OUTR_load in OUT_SEND: ignored (OUT_data unchanged), OUT_drop<=1.
//   OUT_ready in OUT_IDLE is ignored. Minimum OUT round trip: load at N, valid N+1,
//    accept at N+1 edge, FGO=1 at N+2.
//  Sticky flags clear only on reset. INT_req follows flags same cycle (no added latency).
//  Reset asserted mid-transfer discards FIFO contents and any pending OUTR byte.
// TESTING
//  1 Reset: after reset high 1 cycle -> FGI=0, FGO=1, IN_ready=1, OUT_valid=0, INT_req=0.
//  2 Push 0x41,0x42,0x43,0x44 back-to-back -> IN_ready=0 after 4th; 0x45 held off;
//    INP_take x4 -> INPR 0x41..0x44 in order, then FGI=0, IN_ready=1.
//  3 Count=2, simultaneous push 0x55 and INP_take -> count stays 2, FGI=1, 0x55 popped 2 later.
//  4 OUTR_load AC_low=0x7A, OUT_ready=0 for 3 cycles -> OUT_valid=1, OUT_data=0x7A, FGO=0
//    held; second OUTR_load 0x11 -> OUT_drop=1, data stays 0x7A; OUT_ready=1 -> FGO=1 next.
//  5 Empty FIFO, INP_take=1 -> IN_ovf=1, FGI=0, INPR=0; IEN_out=1 with FGO=1 -> INT_req=1.
//  6 Reset asserted with FIFO count=3 and OUT_SEND -> next cycle all reset values; push after
//    reset lands as new head.

Source files
------------

// File: rtl/io_controller.sv
// io_controller: character I/O sequencer for the basic computer.
// Input side buffers device bytes in a small FIFO that presents its head as
// INPR and its non-empty status as FGI. Output side holds one OUTR byte and
// offers it to the output device over a valid/ready handshake, with FGO
// reporting whether OUTR is free. INT_req is raised when interrupts are
// enabled and either flag is set.
// DEPTH must be a power of two and at least 2 so that the pointers wrap
// naturally.
module io_controller #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              IN_valid_i,
    input  logic [DATA_W-1:0] IN_data_i,
    output logic              IN_ready_o,
    input  logic              INP_take_i,
    output logic [DATA_W-1:0] INPR_o,
    output logic              FGI_o,
    input  logic              OUTR_load_i,
    input  logic [DATA_W-1:0] AC_low_i,
    output logic              OUT_valid_o,
    output logic [DATA_W-1:0] OUT_data_o,
    input  logic              OUT_ready_i,
    output logic              FGO_o,
    input  logic              IEN_out_i,
    output logic              INT_req_o,
    output logic              IN_ovf_o,
    output logic              OUT_drop_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        OUT_IDLE,
        OUT_SEND
    } outState_e;

    // Input FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [CW-1:0]     count_q, count_d;

    // Output side state
    outState_e         outState_q, outState_d;
    logic [DATA_W-1:0] outData_q, outData_d;

    // Sticky error flags
    logic              inOvf_q, inOvf_d;
    logic              outDrop_q, outDrop_d;

    logic              fifoFull;
    logic              fifoEmpty;
    logic              push;
    logic              pop;

    // Full/empty come from the registered count only, so a pop in the same
    // cycle never opens room for a push and no input reaches INPR/FGI combinationally.
    assign fifoFull  = (count_q == CW'(DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign push      = IN_valid_i & ~fifoFull;
    assign pop       = INP_take_i & ~fifoEmpty;

    assign IN_ready_o  = ~fifoFull;
    assign FGI_o       = ~fifoEmpty;
    assign INPR_o      = fifoEmpty ? '0 : mem_q[rdPtr_q];

    assign OUT_valid_o = (outState_q == OUT_SEND);
    assign FGO_o       = (outState_q == OUT_IDLE);
    assign OUT_data_o  = outData_q;

    assign IN_ovf_o    = inOvf_q;
    assign OUT_drop_o  = outDrop_q;
    assign INT_req_o   = IEN_out_i & (FGI_o | FGO_o);

    // Next pointers, occupancy and overflow flag for the input FIFO
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        inOvf_d = inOvf_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (INP_take_i && fifoEmpty) begin
            inOvf_d = 1'b1;
        end
    end

    // FIFO registers; reset discards any buffered bytes
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            inOvf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            inOvf_q <= inOvf_d;
            if (push) begin
                mem_q[wrPtr_q] <= IN_data_i;
            end
        end
    end

    // Output handshake: capture AC_low when idle, hold it until the device accepts
    always_comb begin
        outState_d = outState_q;
        outData_d  = outData_q;
        outDrop_d  = outDrop_q;
        unique case (outState_q)
            OUT_IDLE: begin
                if (OUTR_load_i) begin
                    outData_d  = AC_low_i;
                    outState_d = OUT_SEND;
                end
            end
            OUT_SEND: begin
                if (OUTR_load_i) begin
                    outDrop_d = 1'b1;
                end
                if (OUT_ready_i) begin
                    outState_d = OUT_IDLE;
                end
            end
            default: begin
                outState_d = OUT_IDLE;
            end
        endcase
    end

    // Output state register; reset drops any byte still waiting for the device
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            outState_q <= OUT_IDLE;
            outData_q  <= '0;
            outDrop_q  <= 1'b0;
        end else begin
            outState_q <= outState_d;
            outData_q  <= outData_d;
            outDrop_q  <= outDrop_d;
        end
    end

endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller: directed and randomized checks of io_controller against
// a queue-based behavioural model of the character I/O rules.
module tb_io_controller;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;

    logic              clock;
    logic              reset;
    logic              inValid;
    logic [DATA_W-1:0] inData;
    logic              inReady;
    logic              inpTake;
    logic [DATA_W-1:0] inpr;
    logic              fgi;
    logic              outrLoad;
    logic [DATA_W-1:0] acLow;
    logic              outValid;
    logic [DATA_W-1:0] outData;
    logic              outReady;
    logic              fgo;
    logic              ienOut;
    logic              intReq;
    logic              inOvf;
    logic              outDrop;

    int testsRun;
    int testsFailed;

    // Behavioural model state
    logic [DATA_W-1:0] modelQ[$];
    bit                modelBusy;
    logic [DATA_W-1:0] modelByte;
    bit                modelOvf;
    bit                modelDrop;

    io_controller #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .IN_valid_i  (inValid),
        .IN_data_i   (inData),
        .IN_ready_o  (inReady),
        .INP_take_i  (inpTake),
        .INPR_o      (inpr),
        .FGI_o       (fgi),
        .OUTR_load_i (outrLoad),
        .AC_low_i    (acLow),
        .OUT_valid_o (outValid),
        .OUT_data_o  (outData),
        .OUT_ready_i (outReady),
        .FGO_o       (fgo),
        .IEN_out_i   (ienOut),
        .INT_req_o   (intReq),
        .IN_ovf_o    (inOvf),
        .OUT_drop_o  (outDrop)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Compare every DUT output with what the model says the flags and registers should be
    task automatic checkOutput(input string tag);
        bit expFgi;
        bit expFgo;
        expFgi = (modelQ.size() > 0);
        expFgo = !modelBusy;
        chk({tag, ".FGI"},       32'(fgi),      32'(expFgi));
        chk({tag, ".INPR"},      32'(inpr),     expFgi ? 32'(modelQ[0]) : 32'(0));
        chk({tag, ".IN_ready"},  32'(inReady),  32'(modelQ.size() < DEPTH));
        chk({tag, ".FGO"},       32'(fgo),      32'(expFgo));
        chk({tag, ".OUT_valid"}, 32'(outValid), 32'(modelBusy));
        chk({tag, ".OUT_data"},  32'(outData),  32'(modelByte));
        chk({tag, ".IN_ovf"},    32'(inOvf),    32'(modelOvf));
        chk({tag, ".OUT_drop"},  32'(outDrop),  32'(modelDrop));
        chk({tag, ".INT_req"},   32'(intReq),   32'(ienOut & (expFgi | expFgo)));
    endtask

    // Drive one cycle of inputs, advance the model by the I/O rules, clock, then check
    task automatic applyStimulus(input bit rst, input bit iv, input logic [DATA_W-1:0] id,
                                 input bit take, input bit load, input logic [DATA_W-1:0] ac,
                                 input bit ordy, input bit ien, input string tag);
        logic [DATA_W-1:0] dummy;
        bit roomBefore;
        reset    = rst;
        inValid  = iv;
        inData   = id;
        inpTake  = take;
        outrLoad = load;
        acLow    = ac;
        outReady = ordy;
        ienOut   = ien;
        if (rst) begin
            modelQ.delete();
            modelBusy = 0;
            modelByte = '0;
            modelOvf  = 0;
            modelDrop = 0;
        end else begin
            roomBefore = (modelQ.size() < DEPTH);
            if (take) begin
                if (modelQ.size() == 0) modelOvf = 1;
                else dummy = modelQ.pop_front();
            end
            if (iv && roomBefore) modelQ.push_back(id);
            if (!modelBusy) begin
                if (load) begin
                    modelBusy = 1;
                    modelByte = ac;
                end
            end else begin
                if (load) modelDrop = 1;
                if (ordy) modelBusy = 0;
            end
        end
        @(posedge clock);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset    = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        inpTake  = 1'b0;
        outrLoad = 1'b0;
        acLow    = '0;
        outReady = 1'b0;
        ienOut   = 1'b0;

        // Reset values
        applyStimulus(1, 0, 8'h00, 0, 0, 8'h00, 0, 0, "reset");
        chk("reset_fgi", 32'(fgi), 32'(0));
        chk("reset_fgo", 32'(fgo), 32'(1));
        chk("reset_in_ready", 32'(inReady), 32'(1));
        chk("reset_out_valid", 32'(outValid), 32'(0));
        chk("reset_int_req", 32'(intReq), 32'(0));

        // Fill the FIFO, push against full, then drain in order
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 8'h41 + 8'(i), 0, 0, 8'h00, 0, 0, "fill");
        chk("full_in_ready", 32'(inReady), 32'(0));
        applyStimulus(0, 1, 8'h45, 0, 0, 8'h00, 0, 0, "held_off");
        chk("held_off_in_ready", 32'(inReady), 32'(0));
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(inpr), 32'(8'h41 + 8'(i)));
            applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, "drain");
        end
        chk("drained_fgi", 32'(fgi), 32'(0));
        chk("drained_in_ready", 32'(inReady), 32'(1));

        // Pop while full does not allow a push in the same cycle
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 8'h60 + 8'(i), 0, 0, 8'h00, 0, 0, "refill");
        applyStimulus(0, 1, 8'h99, 1, 0, 8'h00, 0, 0, "full_pop_push");
        chk("full_pop_no_push_ready", 32'(inReady), 32'(1));
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, "empty_again");

        // Simultaneous push and pop at count 2
        applyStimulus(0, 1, 8'h10, 0, 0, 8'h00, 0, 0, "cnt2_a");
        applyStimulus(0, 1, 8'h20, 0, 0, 8'h00, 0, 0, "cnt2_b");
        applyStimulus(0, 1, 8'h55, 1, 0, 8'h00, 0, 0, "push_pop");
        chk("push_pop_fgi", 32'(fgi), 32'(1));
        chk("push_pop_head", 32'(inpr), 32'(8'h20));
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, "pop_20");
        chk("head_55", 32'(inpr), 32'(8'h55));
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, "pop_55");
        chk("after_55_fgi", 32'(fgi), 32'(0));

        // Output handshake with stall and a dropped second load
        applyStimulus(0, 0, 8'h00, 0, 1, 8'h7A, 0, 0, "out_load");
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "out_stall");
        chk("stall_data", 32'(outData), 32'(8'h7A));
        chk("stall_fgo", 32'(fgo), 32'(0));
        applyStimulus(0, 0, 8'h00, 0, 1, 8'h11, 0, 0, "out_drop");
        chk("drop_flag", 32'(outDrop), 32'(1));
        chk("drop_data", 32'(outData), 32'(8'h7A));
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, "out_accept");
        chk("accept_fgo", 32'(fgo), 32'(1));
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, "ready_in_idle");

        // Minimum round trip: load, accept on the first valid cycle
        applyStimulus(0, 0, 8'h00, 0, 1, 8'hC3, 1, 0, "rt_load");
        chk("rt_valid", 32'(outValid), 32'(1));
        applyStimulus(0, 0, 8'h00, 0, 0, 8'h00, 1, 0, "rt_accept");
        chk("rt_fgo", 32'(fgo), 32'(1));

        // Underflow and interrupt request
        applyStimulus(0, 0, 8'h00, 1, 0, 8'h00, 0, 0, "underflow");
        chk("ovf_flag", 32'(inOvf), 32'(1));
        chk("ovf_inpr", 32'(inpr), 32'(0));
        ienOut = 1'b1;
        #1;
        checkOutput("ien_comb");
        chk("int_req_fgo", 32'(intReq), 32'(1));

        // Reset in the middle of activity
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1, 8'hA0 + 8'(i), 0, 0, 8'h00, 0, 1, "pre_rst_fill");
        applyStimulus(0, 0, 8'h00, 0, 1, 8'h5C, 0, 1, "pre_rst_send");
        applyStimulus(1, 1, 8'hEE, 1, 1, 8'h33, 1, 1, "mid_reset");
        chk("mid_reset_fgi", 32'(fgi), 32'(0));
        chk("mid_reset_out_data", 32'(outData), 32'(0));
        applyStimulus(0, 1, 8'hB7, 0, 0, 8'h00, 0, 1, "post_rst_push");
        chk("post_rst_head", 32'(inpr), 32'(8'hB7));

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 1) == 1),
                          8'($urandom),
                          ($urandom_range(0, 9) < 4),
                          ($urandom_range(0, 9) < 3),
                          8'($urandom),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 1) == 1),
                          "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
